// File: rtl/alu_mdu_pkg.sv
// alu_mdu_pkg: shared op codes for the execute unit.
//   alu_op_e : 5-bit op code. Single-cycle ALU codes occupy 0..11;
//              the multiply/divide codes occupy 16..23 so they never
//              collide with ALU codes.
//   is_mdu() : true for the iterative multiply/divide op codes.
package alu_mdu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_SLT    = 5'd5,
    OP_SLTU   = 5'd6,
    OP_SLL    = 5'd7,
    OP_SRL    = 5'd8,
    OP_SRA    = 5'd9,
    OP_SRC0   = 5'd10,
    OP_SRC1   = 5'd11,
    OP_MUL    = 5'd16,
    OP_MULH   = 5'd17,
    OP_MULHSU = 5'd18,
    OP_MULHU  = 5'd19,
    OP_DIV    = 5'd20,
    OP_DIVU   = 5'd21,
    OP_REM    = 5'd22,
    OP_REMU   = 5'd23
  } alu_op_e;

  function automatic logic is_mdu(input logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// alu_mdu_if: operand/result handshake bundle of the execute unit.
//   in_valid/in_ready   : operand handshake (alu_src0, alu_src1, alu_op)
//   flush               : synchronous abort of any op in flight
//   out_valid/out_ready : result handshake (alu_res)
//   busy                : unit is iterating a multiply/divide
// Modports: master = pipeline side, slave = execute unit.
interface alu_mdu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] alu_src0;
  logic [WIDTH-1:0] alu_src1;
  logic [4:0]       alu_op;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_res;
  logic             busy;

  modport master (
    output in_valid, alu_src0, alu_src1, alu_op, flush, out_ready,
    input  in_ready, out_valid, alu_res, busy
  );

  modport slave (
    input  in_valid, alu_src0, alu_src1, alu_op, flush, out_ready,
    output in_ready, out_valid, alu_res, busy
  );
endinterface

// File: rtl/alu_mdu_iter.sv
// alu_mdu_iter: iterative multiply/divide datapath (mdu_iter).
//   clk, rst : clock, asynchronous active-high reset
//   flush_i  : abort the running operation
//   start_i  : capture op_i/src0_i/src1_i and begin WIDTH iterations
//   done_o   : high in the last iteration cycle; res_o valid then
//   res_o    : sign-corrected result (combinational from final step)
// Multiply is radix-2 shift-add on magnitudes into {hi,lo}; divide is
// restoring division with the remainder in hi and quotient in lo.
module alu_mdu_iter
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             start_i,
  input  logic [4:0]       op_i,
  input  logic [WIDTH-1:0] src0_i,
  input  logic [WIDTH-1:0] src1_i,
  output logic             done_o,
  output logic [WIDTH-1:0] res_o
);

  localparam int CW = $clog2(WIDTH);

  logic             run_q;
  logic             neg_q;
  logic [4:0]       op_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, opnd_q;

  logic             is_mul_d, a_sgn, b_sgn, neg_d;
  logic [WIDTH-1:0] mag0, mag1;

  logic             is_mul_q;
  logic [WIDTH:0]   mul_sum, div_sh;
  logic [WIDTH-1:0] div_sub, hi_n, lo_n;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod, prod_f;

  // Operand preparation at start
  always_comb begin
    is_mul_d = op_i inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    a_sgn    = (op_i inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && src0_i[WIDTH-1];
    b_sgn    = (op_i inside {OP_MUL, OP_MULH, OP_DIV, OP_REM}) && src1_i[WIDTH-1];
    mag0     = a_sgn ? -src0_i : src0_i;
    mag1     = b_sgn ? -src1_i : src1_i;
    // Divide by zero leaves the all-ones quotient magnitude unnegated;
    // remainder takes the dividend's sign.
    case (op_i)
      OP_DIV, OP_DIVU: neg_d = (a_sgn ^ b_sgn) && (|src1_i);
      OP_REM, OP_REMU: neg_d = a_sgn;
      default:         neg_d = a_sgn ^ b_sgn;
    endcase
  end

  // One iteration step
  always_comb begin
    is_mul_q = op_q inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_sh   = {hi_q, lo_q[WIDTH-1]};
    div_ge   = div_sh >= {1'b0, opnd_q};
    div_sub  = div_sh[WIDTH-1:0] - opnd_q;
    if (is_mul_q) begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      hi_n = div_ge ? div_sub : div_sh[WIDTH-1:0];
      lo_n = {lo_q[WIDTH-2:0], div_ge};
    end
  end

  // Result from the final step, so WIDTH iterations fit in WIDTH cycles
  always_comb begin
    done_o = run_q && (cnt_q == CW'(WIDTH - 1));
    prod   = {hi_n, lo_n};
    prod_f = neg_q ? -prod : prod;
    res_o  = '0;
    case (op_q)
      OP_MUL:                      res_o = prod_f[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res_o = prod_f[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:             res_o = neg_q ? -lo_n : lo_n;
      OP_REM, OP_REMU:             res_o = neg_q ? -hi_n : hi_n;
      default:                     res_o = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q  <= 1'b0;
      neg_q  <= 1'b0;
      op_q   <= '0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
    end else if (flush_i) begin
      run_q <= 1'b0;
    end else if (start_i) begin
      run_q  <= 1'b1;
      neg_q  <= neg_d;
      op_q   <= op_i;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= is_mul_d ? mag1 : mag0;
      opnd_q <= is_mul_d ? mag0 : mag1;
    end else if (run_q) begin
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q + CW'(1);
      if (done_o) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: EX-stage execute unit, single-cycle ALU plus iterative MDU.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : alu_mdu_if.slave
//     in_valid/in_ready, alu_src0, alu_src1, alu_op : operand handshake
//     flush                                          : abort op in flight
//     out_valid/out_ready, alu_res                   : registered result
//     busy                                           : iterating (CALC)
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     rst,
  alu_mdu_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] alu_val;
  logic [SHW-1:0]   shamt;
  logic             mdu_start, mdu_done;
  logic [WIDTH-1:0] mdu_res;

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == CALC);
  assign bus.out_valid = (state_q == DONE);
  assign bus.alu_res   = res_q;

  always_comb begin
    shamt   = bus.alu_src1[SHW-1:0];
    alu_val = '0;
    case (bus.alu_op)
      OP_ADD:  alu_val = bus.alu_src0 + bus.alu_src1;
      OP_SUB:  alu_val = bus.alu_src0 - bus.alu_src1;
      OP_AND:  alu_val = bus.alu_src0 & bus.alu_src1;
      OP_OR:   alu_val = bus.alu_src0 | bus.alu_src1;
      OP_XOR:  alu_val = bus.alu_src0 ^ bus.alu_src1;
      OP_SLT:  alu_val = WIDTH'($signed(bus.alu_src0) < $signed(bus.alu_src1));
      OP_SLTU: alu_val = WIDTH'(bus.alu_src0 < bus.alu_src1);
      OP_SLL:  alu_val = bus.alu_src0 << shamt;
      OP_SRL:  alu_val = bus.alu_src0 >> shamt;
      OP_SRA:  alu_val = $signed(bus.alu_src0) >>> shamt;
      OP_SRC0: alu_val = bus.alu_src0;
      OP_SRC1: alu_val = bus.alu_src1;
      default: alu_val = '0;
    endcase
  end

  // flush outranks everything, including a handshake in the same cycle
  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    mdu_start = 1'b0;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            if (is_mdu(bus.alu_op)) begin
              state_d   = CALC;
              mdu_start = 1'b1;
            end else begin
              state_d = DONE;
              res_d   = alu_val;
            end
          end
        end
        CALC: begin
          if (mdu_done) begin
            state_d = DONE;
            res_d   = mdu_res;
          end
        end
        DONE: begin
          if (bus.out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
    end
  end

  alu_mdu_iter #(.WIDTH(WIDTH)) mdu_iter (
    .clk    (clk),
    .rst    (rst),
    .flush_i(bus.flush),
    .start_i(mdu_start),
    .op_i   (bus.alu_op),
    .src0_i (bus.alu_src0),
    .src1_i (bus.alu_src1),
    .done_o (mdu_done),
    .res_o  (mdu_res)
  );

endmodule
